conv_inst_sequencer: RTL and testbench

Hardware replacement for the hand-driven instruction stream that runs one output-stationary-free weight-stationary convolution tile on `core`. It generates the 64-bit `inst` word cycle by cycle for every kernel position kij:
- L0 weight fill
- PE weight load
- settle gap
- activation streaming
- OFIFO drain with output-pixel (onij) address generation into PSUM SRAM

It is parametrised in array size, input size and kernel size. It adds features the hand-driven flow lacks:
- all kernels are preloaded at a base address
- onij 0 is written correctly
- drain timeout with an error flag

---
 rtl/conv_inst_sequencer_pkg.sv | 53 +++++
 rtl/conv_inst_sequencer_if.sv | 22 ++
 rtl/conv_inst_sequencer_onij.sv | 57 +++++
 rtl/conv_inst_sequencer.sv | 167 ++++++++++++++++
 tb/tb_conv_inst_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_inst_sequencer_pkg.sv
// Shared definitions for the convolution instruction sequencer: inst bit map, FSM states, default geometry.
package conv_seq_pkg;

  localparam int INST_W         = 64;
  localparam int INST_LOAD      = 0;
  localparam int INST_EXECUTE   = 1;
  localparam int INST_L0_WR     = 2;
  localparam int INST_L0_RD     = 3;
  localparam int INST_IFIFO_RD  = 4;
  localparam int INST_IFIFO_WR  = 5;
  localparam int INST_OFIFO_RD  = 6;
  localparam int INST_AXMEM_LSB = 7;
  localparam int INST_WEN_XMEM  = 18;
  localparam int INST_CEN_XMEM  = 19;
  localparam int INST_APMEM_LSB = 20;
  localparam int INST_WEN_PMEM  = 31;
  localparam int INST_CEN_PMEM  = 32;
  localparam int INST_ACC       = 33;
  localparam int INST_SFU       = 34;
  localparam int INST_REN_PMEM  = 35;
  localparam int INST_DEBUG     = 63;

  localparam int DEF_ROW  = 8;
  localparam int DEF_COL  = 8;
  localparam int DEF_IN_W = 6;
  localparam int DEF_K    = 3;

  localparam int NIJ  = DEF_IN_W * DEF_IN_W;
  localparam int NKIJ = DEF_K * DEF_K;
  localparam int O_W  = DEF_IN_W - DEF_K + 1;
  localparam int ONIJ = O_W * O_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WFILL,
    S_WLOAD,
    S_SETTLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  // Both SRAMs deselected, xmem write-enable parked inactive.
  function automatic logic [INST_W-1:0] idle_inst();
    logic [INST_W-1:0] w;
    w                = '0;
    w[INST_WEN_XMEM] = 1'b1;
    w[INST_CEN_XMEM] = 1'b1;
    w[INST_CEN_PMEM] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/conv_inst_sequencer_if.sv
// Control/status bundle between the sequencer and its host: start/ofifo_valid in, inst word and status out.
interface conv_inst_sequencer_if #(
  parameter int KIJ_W = 4
);
  logic             start;
  logic             ofifo_valid;
  logic [63:0]      inst;
  logic             busy;
  logic             done;
  logic             err_timeout;
  logic [KIJ_W-1:0] kij_idx;

  modport master (
    input  start, ofifo_valid,
    output inst, busy, done, err_timeout, kij_idx
  );

  modport slave (
    output start, ofifo_valid,
    input  inst, busy, done, err_timeout, kij_idx
  );
endinterface

// File: rtl/conv_inst_sequencer_onij.sv
// Output-pixel address generator: walks nij incrementally and maps it to onij for the current kernel offset.
module onij_addr_gen #(
  parameter int IN_W   = 6,
  parameter int K      = 3,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              next_kij,
  input  logic              adv,
  output logic              valid,
  output logic [ADDR_W-1:0] addr
);
  localparam int O_W_L = IN_W - K + 1;
  localparam int CW    = $clog2(IN_W) + 1;

  logic [CW-1:0] nx, ny, kx, ky, ox, oy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nx <= '0;
      ny <= '0;
      kx <= '0;
      ky <= '0;
    end else if (init) begin
      nx <= '0;
      ny <= '0;
      kx <= '0;
      ky <= '0;
    end else if (next_kij) begin
      nx <= '0;
      ny <= '0;
      if (kx == CW'(K - 1)) begin
        kx <= '0;
        ky <= ky + 1'b1;
      end else begin
        kx <= kx + 1'b1;
      end
    end else if (adv) begin
      if (nx == CW'(IN_W - 1)) begin
        nx <= '0;
        ny <= ny + 1'b1;
      end else begin
        nx <= nx + 1'b1;
      end
    end
  end

  // Rows whose shifted position falls outside the output map are discarded.
  always_comb begin
    ox    = nx - kx;
    oy    = ny - ky;
    valid = (nx >= kx) && (ny >= ky) && (ox < CW'(O_W_L)) && (oy < CW'(O_W_L));
    addr  = ADDR_W'(oy) * ADDR_W'(O_W_L) + ADDR_W'(ox);
  end
endmodule

// File: rtl/conv_inst_sequencer.sv
// Generates the per-kernel-position core instruction stream: weight fill/load, settle, stream, OFIFO drain.
module conv_inst_sequencer
  import conv_seq_pkg::*;
#(
  parameter int ROW       = DEF_ROW,
  parameter int COL       = DEF_COL,
  parameter int IN_W      = DEF_IN_W,
  parameter int K         = DEF_K,
  parameter int ADDR_W    = 11,
  parameter int WGT_BASE  = 1024,
  parameter int GAP       = 10,
  parameter int DRAIN_MAX = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  conv_inst_sequencer_if.master  bus
);
  localparam int NIJ_L  = IN_W * IN_W;
  localparam int NKIJ_L = K * K;
  localparam int KIJ_W  = $clog2(NKIJ_L);
  localparam int CNT_W  = 16;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, drained, drained_nxt;
  logic [KIJ_W-1:0]   kij, kij_nxt;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic               busy_q, done_q, err_q, err_d;
  logic               rd, run_start, kij_next, pm_valid;
  logic [ADDR_W-1:0]  pm_addr, fill_col;

  onij_addr_gen #(.IN_W(IN_W), .K(K), .ADDR_W(ADDR_W)) u_onij (
    .clk      (clk),
    .reset    (reset),
    .init     (run_start),
    .next_kij (kij_next),
    .adv      (rd),
    .valid    (pm_valid),
    .addr     (pm_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      drained <= '0;
      kij     <= '0;
      inst_q  <= idle_inst();
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      drained <= drained_nxt;
      kij     <= kij_nxt;
      inst_q  <= inst_d;
      busy_q  <= (state_nxt != S_IDLE);
      done_q  <= (state == S_DONE);
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    drained_nxt = drained;
    kij_nxt     = kij;
    err_d       = err_q;
    run_start   = 1'b0;
    kij_next    = 1'b0;
    inst_d      = idle_inst();
    fill_col    = (cnt < CNT_W'(COL)) ? cnt[ADDR_W-1:0] : ADDR_W'(COL - 1);

    // OFIFO drain overlays whatever the streaming phase is issuing.
    rd = ((state == S_STREAM) || (state == S_DRAIN)) && bus.ofifo_valid
         && (drained < CNT_W'(NIJ_L));
    if (rd) begin
      drained_nxt           = drained + 1'b1;
      inst_d[INST_OFIFO_RD] = 1'b1;
      inst_d[INST_ACC]      = (kij != '0);
      inst_d[INST_SFU]      = (kij == '0);
      if (pm_valid) begin
        inst_d[INST_CEN_PMEM]                 = 1'b0;
        inst_d[INST_WEN_PMEM]                 = 1'b1;
        inst_d[INST_APMEM_LSB +: ADDR_W]      = pm_addr;
      end
    end

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (bus.start) begin
          state_nxt   = S_WFILL;
          kij_nxt     = '0;
          drained_nxt = '0;
          err_d       = 1'b0;
          run_start   = 1'b1;
        end
      end
      S_WFILL: begin
        inst_d[INST_CEN_XMEM]            = 1'b0;
        inst_d[INST_AXMEM_LSB +: ADDR_W] = ADDR_W'(WGT_BASE) + ADDR_W'(kij) * ADDR_W'(COL) + fill_col;
        inst_d[INST_L0_WR]               = (cnt != '0);
        if (cnt == CNT_W'(COL)) begin
          state_nxt = S_WLOAD;
          cnt_nxt   = '0;
        end
      end
      S_WLOAD: begin
        inst_d[INST_L0_RD] = 1'b1;
        inst_d[INST_LOAD]  = (cnt != '0);
        if (cnt == CNT_W'(COL + ROW)) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt == CNT_W'(GAP - 1)) begin
          state_nxt = S_STREAM;
          cnt_nxt   = '0;
        end
      end
      S_STREAM: begin
        inst_d[INST_CEN_XMEM]            = 1'b0;
        inst_d[INST_AXMEM_LSB +: ADDR_W] = cnt[ADDR_W-1:0];
        inst_d[INST_L0_WR]               = 1'b1;
        inst_d[INST_L0_RD]               = 1'b1;
        inst_d[INST_EXECUTE]             = 1'b1;
        if (cnt == CNT_W'(NIJ_L - 1)) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end
      end
      S_DRAIN: begin
        if ((drained_nxt == CNT_W'(NIJ_L)) || (cnt == CNT_W'(DRAIN_MAX - 1))) begin
          if (drained_nxt != CNT_W'(NIJ_L)) begin
            err_d = 1'b1;
          end
          cnt_nxt     = '0;
          drained_nxt = '0;
          if (kij == KIJ_W'(NKIJ_L - 1)) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WFILL;
            kij_nxt   = kij + 1'b1;
            kij_next  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        kij_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.inst        = inst_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_timeout = err_q;
  assign bus.kij_idx     = kij;
endmodule

// File: tb/tb_conv_inst_sequencer.sv
// Randomized bench: two sequencer geometries checked cycle by cycle against a phase-table reference model.
module tb_conv_inst_sequencer;
  localparam int GAP   = 10;
  localparam int DMAX  = 64;
  localparam int WBASE = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic ov    = 1'b0;
  int   sel   = 0;

  always #5 clk = ~clk;

  conv_inst_sequencer_if #(.KIJ_W(4)) if_a ();
  conv_inst_sequencer_if #(.KIJ_W(2)) if_b ();

  assign if_a.start       = start && (sel == 0);
  assign if_b.start       = start && (sel == 1);
  assign if_a.ofifo_valid = ov;
  assign if_b.ofifo_valid = ov;

  conv_inst_sequencer dut_a (.clk(clk), .reset(reset), .bus(if_a));
  conv_inst_sequencer #(.ROW(4), .COL(4), .IN_W(5), .K(2)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  logic [63:0] o_inst;
  logic        o_busy, o_done, o_err;
  int          o_kij;

  always_comb begin
    o_inst = (sel == 0) ? if_a.inst        : if_b.inst;
    o_busy = (sel == 0) ? if_a.busy        : if_b.busy;
    o_done = (sel == 0) ? if_a.done        : if_b.done;
    o_err  = (sel == 0) ? if_a.err_timeout : if_b.err_timeout;
    o_kij  = (sel == 0) ? int'(if_a.kij_idx) : int'(if_b.kij_idx);
  end

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_prev;
  logic        err_state;
  int          rd_seen, wr_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] idle_w();
    logic [63:0] w;
    w     = '0;
    w[18] = 1'b1;
    w[19] = 1'b1;
    w[32] = 1'b1;
    return w;
  endfunction

  // Word issued at position pos of the fill/load/settle preamble of kernel kij.
  function automatic logic [63:0] pre_w(input int pos, input int kij, input int row, input int col);
    logic [63:0] w;
    int c;
    w = idle_w();
    if (pos < col + 1) begin
      c        = (pos < col) ? pos : col - 1;
      w[19]    = 1'b0;
      w[17:7]  = 11'(WBASE + kij * col + c);
      w[2]     = (pos >= 1);
    end else if (pos < 2 * col + row + 2) begin
      w[3] = 1'b1;
      w[0] = (pos - (col + 1)) >= 1;
    end
    return w;
  endfunction

  // Inst word seen one cycle later is the model's word for the current cycle.
  task automatic step(input logic [63:0] w, input logic e_busy, input logic e_done,
                      input int e_kij, input logic ov_n);
    @(negedge clk);
    chk("inst", o_inst, exp_prev);
    chk("busy", o_busy, e_busy);
    chk("done", o_done, e_done);
    chk("err_timeout", o_err, err_state);
    chk("kij_idx", o_kij, e_kij);
    if (o_inst[6])   rd_seen++;
    if (!o_inst[32]) wr_seen++;
    start    = 1'b0;
    ov       = ov_n;
    exp_prev = w;
  endtask

  // mode 0: ofifo_valid tied high, 1: random, 2: random but starved in DRAIN of kernel to_kij
  task automatic run_seq(input int s, input int row, input int col, input int in_w, input int k,
                         input int mode, input int to_kij);
    int nij, nkij, ow, pre, reads, sc, kx, ky, x, y, ox, oy;
    logic o;
    logic [63:0] w;
    sel  = s;
    nij  = in_w * in_w;
    nkij = k * k;
    ow   = in_w - k + 1;
    pre  = 2 * col + row + 2 + GAP;
    step(idle_w(), 1'b0, 1'b0, 0, 1'b0);
    start     = 1'b1;
    err_state = 1'b0;
    rd_seen   = 0;
    wr_seen   = 0;
    for (int kij = 0; kij < nkij; kij++) begin
      kx = kij % k;
      ky = kij / k;
      for (int pos = 0; pos < pre; pos++) begin
        step(pre_w(pos, kij, row, col), 1'b1, 1'b0, kij, 1'($urandom % 2));
        if (pos == 3) start = 1'b1;
      end
      reads = 0;
      sc    = 0;
      forever begin
        case (mode)
          0:       o = 1'b1;
          1:       o = ($urandom % 4) != 0;
          default: o = (kij == to_kij && sc >= nij) ? 1'b0 : (($urandom % 4) != 0);
        endcase
        w = idle_w();
        if (sc < nij) begin
          w[19]   = 1'b0;
          w[17:7] = 11'(sc);
          w[1]    = 1'b1;
          w[2]    = 1'b1;
          w[3]    = 1'b1;
        end
        if (o && reads < nij) begin
          x  = reads % in_w;
          y  = reads / in_w;
          ox = x - kx;
          oy = y - ky;
          w[6]  = 1'b1;
          w[33] = (kij != 0);
          w[34] = (kij == 0);
          if (ox >= 0 && ox < ow && oy >= 0 && oy < ow) begin
            w[32]    = 1'b0;
            w[31]    = 1'b1;
            w[30:20] = 11'(oy * ow + ox);
          end
          reads++;
        end
        step(w, 1'b1, 1'b0, kij, o);
        if (sc >= nij) begin
          if (reads == nij) break;
          if (sc - nij == DMAX - 1) begin
            err_state = 1'b1;
            break;
          end
        end
        sc++;
      end
    end
    step(idle_w(), 1'b1, 1'b0, nkij - 1, 1'b0);
    step(idle_w(), 1'b0, 1'b1, 0, 1'b0);
    step(idle_w(), 1'b0, 1'b0, 0, 1'b0);
    if (mode == 0) begin
      chk("ofifo_rd_count", rd_seen, nkij * nij);
      chk("pmem_wr_count", wr_seen, nkij * ow * ow);
    end
    if (mode == 2) chk("timeout_sticky", o_err, 1);
  endtask

  task automatic reset_mid_stream();
    logic hit;
    sel = 0;
    step(idle_w(), 1'b0, 1'b0, 0, 1'b1);
    start     = 1'b1;
    err_state = 1'b0;
    hit       = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (o_kij == 4 && o_inst[1]) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_kij4_stream", hit, 1);
    reset = 1'b0;
    #1;
    chk("rst_inst", o_inst, idle_w());
    chk("rst_busy", o_busy, 0);
    chk("rst_kij", o_kij, 0);
    @(negedge clk);
    reset    = 1'b1;
    ov       = 1'b0;
    exp_prev = idle_w();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_inst", o_inst, idle_w());
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_err", o_err, 0);
    chk("reset_kij", o_kij, 0);
    reset     = 1'b1;
    exp_prev  = idle_w();
    err_state = 1'b0;

    run_seq(0, 8, 8, 6, 3, 0, 0);
    run_seq(0, 8, 8, 6, 3, 1, 0);
    run_seq(0, 8, 8, 6, 3, 2, 2);
    run_seq(0, 8, 8, 6, 3, 1, 0);
    run_seq(1, 4, 4, 5, 2, 0, 0);
    run_seq(1, 4, 4, 5, 2, 2, 3);
    run_seq(1, 4, 4, 5, 2, 1, 0);
    reset_mid_stream();
    run_seq(0, 8, 8, 6, 3, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
